vga_mode_ctrl: RTL and testbench
================================

// Module: vga_mode_ctrl
// PURPOSE
//  Mode sequencer for the vga timing core. Holds a 4-entry video-mode table.
//  Drives the core's 8 timing inputs and its init strobe. Accepts mode-change
//  requests over a valid/ready handshake and applies them glitch-free on a
//  frame boundary. Sits between the control plane and vga.
// PARAMETERS
//  DEFAULT_MODE   0        mode index loaded at reset (0..3)
//  INIT_CYCLES    4        cycles init is held high per (re)start, >=1
//  SYNC_TO_FRAME  1        1: wait for sof before switching; 0: switch at once
//  WAIT_TIMEOUT   2000000  max cycles waiting for sof before forced switch, >=1
// PORTS
//  aclk            in   1   clock
//  aresetn         in   1   async active-low reset
//  mode_req_valid  in   1   mode change request
//  mode_req_ready  out  1   request accepted when valid&&ready
//  mode_req_sel    in   2   requested mode index
//  mode_done       out  1   1-cycle pulse: requested mode is active
//  cur_mode        out  2   mode currently driven
//  busy            out  1   1 in any state except S_RUN
//  init            out  1   to vga.init
//  sof             in   1   from vga.sof
//  h_res,h_fp,h_sync,h_bp,v_res,v_fp,v_sync,v_bp  out 16 each  to vga timing inputs
//  pix_tvalid      in   1   monitor tap of source->vga stream
//  pix_tready      in   1   monitor tap of vga.pix_tready
//  underflow_cnt   out  16  starved-pixel count (optional feature)
//  underflow_clr   in   1   clears underflow_cnt (optional feature)
// BEHAVIOUR
//  Mode table (res/fp/sync/bp), H then V:
//   0: 640/16/96/48,   480/10/2/33     1: 800/40/128/88, 600/1/4/23
//   2: 1024/24/136/160, 768/3/6/29     3: 8/2/2/2, 4/1/1/1 (sim mode)
//  Reset values:
//   - state S_START, cur_mode=DEFAULT_MODE, timing outs = table[DEFAULT_MODE]
//   - init=1, mode_req_ready=0, mode_done=0, busy=1, underflow_cnt=0
//  All outputs registered. mode_req_ready = (state==S_RUN).
//  S_START: init=1 for INIT_CYCLES cycles from reset release -> S_RUN.
//  S_RUN: on valid&&ready, latch sel as pend.
//   - sel==cur_mode: no init, mode_done next cycle, stay S_RUN.
//   - else SYNC_TO_FRAME=1 -> S_WAIT_SOF (timeout counter cleared).
//   - else SYNC_TO_FRAME=0 -> S_INIT.
//  S_WAIT_SOF: sof arrives -> S_INIT; timeout counter reaches WAIT_TIMEOUT-1 with
//   no sof -> S_INIT anyway. A sof coincident with the accepting cycle is ignored.
//  S_INIT entry edge: timing outs <= table[pend], cur_mode <= pend, init <= 1
//   all on the same edge. Hold init INIT_CYCLES cycles, then init=0, S_RUN.
//   mode_done pulses in the first S_RUN cycle.
//  Timing outs change only on S_INIT entry; never while init=0.
//  Requests while busy are stalled (ready=0); source holds valid/sel.
//  Reset mid-operation: pending request dropped, return to reset values.
//  Counters sized $clog2(max(INIT_CYCLES,WAIT_TIMEOUT)+1); no wrap possible.
// CONFIGURATION
//  VGA_MODE_CTRL_UNDERFLOW_EN defined:
//   - underflow_cnt += 1 (saturate at 16'hFFFF) each cycle with
//     pix_tready && !pix_tvalid && state==S_RUN.
//   - Cleared on underflow_clr and on S_INIT entry; clr wins over increment.
//  Not defined: underflow_cnt tied 0, underflow_clr/pix_* ignored, no counter logic.
// TESTING
//  1 reset, DEFAULT_MODE=3 -> timing=8/2/2/2,4/1/1/1, init high 4 cycles, busy->0, ready=1
//  2 mode 3, req sel=0 (SYNC=1) -> no init until sof; init 4 cycles from sof edge;
//    h_res=640 on same edge init rises; mode_done 1 pulse; cur_mode=0
//  3 req sel==cur_mode -> ready handshake, mode_done next cycle, init stays 0
//  4 sof held 0, WAIT_TIMEOUT=100 -> S_INIT forced exactly 100 cycles after accept
//  5 aresetn low during S_WAIT_SOF -> all outs = reset values, request lost
//  6 UNDERFLOW_EN: 5 cycles tready&&!tvalid -> cnt=5; clr+starve same cycle -> 0;
//    saturates at FFFF; macro off -> cnt stays 0

Source files
------------

// File: rtl/vga_mode_ctrl.sv
// Mode sequencer for the vga timing core: 4-entry mode table, handshake-driven mode
// switching on a frame boundary. Optional starved-pixel counter: VGA_MODE_CTRL_UNDERFLOW_EN.
module vga_mode_ctrl #(
    parameter int DEFAULT_MODE  = 0,
    parameter int INIT_CYCLES   = 4,
    parameter int SYNC_TO_FRAME = 1,
    parameter int WAIT_TIMEOUT  = 2000000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        mode_req_valid,
    output logic        mode_req_ready,
    input  logic [1:0]  mode_req_sel,
    output logic        mode_done,
    output logic [1:0]  cur_mode,
    output logic        busy,
    output logic        init,
    input  logic        sof,
    output logic [15:0] h_res,
    output logic [15:0] h_fp,
    output logic [15:0] h_sync,
    output logic [15:0] h_bp,
    output logic [15:0] v_res,
    output logic [15:0] v_fp,
    output logic [15:0] v_sync,
    output logic [15:0] v_bp,
    input  logic        pix_tvalid,
    input  logic        pix_tready,
    output logic [15:0] underflow_cnt,
    input  logic        underflow_clr
);

    localparam int CNT_MAX = (INIT_CYCLES > WAIT_TIMEOUT) ? INIT_CYCLES : WAIT_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [1:0]       DEF_MODE  = 2'(DEFAULT_MODE);

    typedef enum logic [1:0] {S_START, S_RUN, S_WAIT_SOF, S_INIT} state_t;

    // Packed as h_res,h_fp,h_sync,h_bp,v_res,v_fp,v_sync,v_bp (MSB first).
    function automatic logic [127:0] mode_timing(input logic [1:0] m);
        case (m)
            2'd1:    return {16'd800, 16'd40, 16'd128, 16'd88, 16'd600, 16'd1, 16'd4, 16'd23};
            2'd2:    return {16'd1024, 16'd24, 16'd136, 16'd160, 16'd768, 16'd3, 16'd6, 16'd29};
            2'd3:    return {16'd8, 16'd2, 16'd2, 16'd2, 16'd4, 16'd1, 16'd1, 16'd1};
            default: return {16'd640, 16'd16, 16'd96, 16'd48, 16'd480, 16'd10, 16'd2, 16'd33};
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       cur_mode_q, cur_mode_d;
    logic [127:0]     timing_q, timing_d;
    logic             init_q, init_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             enter_init;
    logic [1:0]       init_mode;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        cur_mode_d = cur_mode_q;
        timing_d   = timing_q;
        init_d     = init_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        enter_init = 1'b0;
        init_mode  = pend_q;
        case (state_q)
            S_START, S_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    init_d  = 1'b0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = (state_q == S_INIT);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (mode_req_valid && ready_q) begin
                    if (mode_req_sel == cur_mode_q) begin
                        done_d = 1'b1;
                    end else if (SYNC_TO_FRAME != 0) begin
                        pend_d  = mode_req_sel;
                        state_d = S_WAIT_SOF;
                        cnt_d   = '0;
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        pend_d     = mode_req_sel;
                        init_mode  = mode_req_sel;
                        enter_init = 1'b1;
                    end
                end
            end
            S_WAIT_SOF: begin
                if (sof || cnt_q == WAIT_LAST) begin
                    enter_init = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_START;
        endcase
        // Timing outputs, mode and init all move together on the S_INIT entry edge.
        if (enter_init) begin
            state_d    = S_INIT;
            cnt_d      = '0;
            init_d     = 1'b1;
            ready_d    = 1'b0;
            busy_d     = 1'b1;
            cur_mode_d = init_mode;
            timing_d   = mode_timing(init_mode);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_START;
            cnt_q      <= '0;
            pend_q     <= DEF_MODE;
            cur_mode_q <= DEF_MODE;
            timing_q   <= mode_timing(DEF_MODE);
            init_q     <= 1'b1;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            cur_mode_q <= cur_mode_d;
            timing_q   <= timing_d;
            init_q     <= init_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

`ifdef VGA_MODE_CTRL_UNDERFLOW_EN
    logic [15:0] uf_q, uf_d;

    // Clear has priority over a starved cycle; the count saturates rather than wraps.
    always_comb begin
        uf_d = uf_q;
        if (underflow_clr || enter_init) begin
            uf_d = '0;
        end else if (state_q == S_RUN && pix_tready && !pix_tvalid && uf_q != 16'hFFFF) begin
            uf_d = uf_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            uf_q <= '0;
        end else begin
            uf_q <= uf_d;
        end
    end

    assign underflow_cnt = uf_q;
`else
    logic unused_uf_inputs;
    assign unused_uf_inputs = ^{pix_tvalid, pix_tready, underflow_clr};
    assign underflow_cnt    = '0;
`endif

    assign mode_req_ready = ready_q;
    assign mode_done      = done_q;
    assign cur_mode       = cur_mode_q;
    assign busy           = busy_q;
    assign init           = init_q;
    assign h_res          = timing_q[127:112];
    assign h_fp           = timing_q[111:96];
    assign h_sync         = timing_q[95:80];
    assign h_bp           = timing_q[79:64];
    assign v_res          = timing_q[63:48];
    assign v_fp           = timing_q[47:32];
    assign v_sync         = timing_q[31:16];
    assign v_bp           = timing_q[15:0];

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Scoreboard bench for vga_mode_ctrl: directed mode requests, expected mode_done
// contents queued at issue and checked by an independent monitor.
module tb_vga_mode_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        mode_req_valid;
    logic        mode_req_ready;
    logic [1:0]  mode_req_sel;
    logic        mode_done;
    logic [1:0]  cur_mode;
    logic        busy;
    logic        init;
    logic        sof;
    logic [15:0] h_res, h_fp, h_sync, h_bp, v_res, v_fp, v_sync, v_bp;
    logic        pix_tvalid;
    logic        pix_tready;
    logic [15:0] underflow_cnt;
    logic        underflow_clr;

    always #5 aclk = ~aclk;

    vga_mode_ctrl #(
        .DEFAULT_MODE (3),
        .INIT_CYCLES  (4),
        .SYNC_TO_FRAME(1),
        .WAIT_TIMEOUT (100)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .mode_req_valid(mode_req_valid),
        .mode_req_ready(mode_req_ready),
        .mode_req_sel  (mode_req_sel),
        .mode_done     (mode_done),
        .cur_mode      (cur_mode),
        .busy          (busy),
        .init          (init),
        .sof           (sof),
        .h_res         (h_res),
        .h_fp          (h_fp),
        .h_sync        (h_sync),
        .h_bp          (h_bp),
        .v_res         (v_res),
        .v_fp          (v_fp),
        .v_sync        (v_sync),
        .v_bp          (v_bp),
        .pix_tvalid    (pix_tvalid),
        .pix_tready    (pix_tready),
        .underflow_cnt (underflow_cnt),
        .underflow_clr (underflow_clr)
    );

    typedef struct packed {
        logic [1:0]  mode;
        logic [15:0] hr, hf, hs, hb, vr, vf, vs, vb;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t exp_for(input logic [1:0] m);
        exp_t e;
        case (m)
            2'd0: e = '{2'd0, 16'd640, 16'd16, 16'd96, 16'd48, 16'd480, 16'd10, 16'd2, 16'd33};
            2'd1: e = '{2'd1, 16'd800, 16'd40, 16'd128, 16'd88, 16'd600, 16'd1, 16'd4, 16'd23};
            2'd2: e = '{2'd2, 16'd1024, 16'd24, 16'd136, 16'd160, 16'd768, 16'd3, 16'd6, 16'd29};
            default: e = '{2'd3, 16'd8, 16'd2, 16'd2, 16'd2, 16'd4, 16'd1, 16'd1, 16'd1};
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_timing(input string name, input exp_t e);
        chk({name, "_cur_mode"}, 32'(cur_mode), 32'(e.mode));
        chk({name, "_h_res"}, 32'(h_res), 32'(e.hr));
        chk({name, "_h_fp"}, 32'(h_fp), 32'(e.hf));
        chk({name, "_h_sync"}, 32'(h_sync), 32'(e.hs));
        chk({name, "_h_bp"}, 32'(h_bp), 32'(e.hb));
        chk({name, "_v_res"}, 32'(v_res), 32'(e.vr));
        chk({name, "_v_fp"}, 32'(v_fp), 32'(e.vf));
        chk({name, "_v_sync"}, 32'(v_sync), 32'(e.vs));
        chk({name, "_v_bp"}, 32'(v_bp), 32'(e.vb));
    endtask

    task automatic chk_reset(input string name);
        chk_timing(name, exp_for(2'd3));
        chk({name, "_init"}, 32'(init), 32'd1);
        chk({name, "_ready"}, 32'(mode_req_ready), 32'd0);
        chk({name, "_done"}, 32'(mode_done), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd1);
        chk({name, "_uf_cnt"}, 32'(underflow_cnt), 32'd0);
    endtask

    // Counts consecutive sampled cycles with init high, starting from the current one.
    task automatic count_init(input string name);
        int c = 0;
        while (init && c < 20) begin
            c++;
            tick();
        end
        chk(name, 32'(c), 32'd4);
    endtask

    task automatic request(input logic [1:0] s, input logic sof_with);
        int w = 0;
        mode_req_valid = 1'b1;
        mode_req_sel   = s;
        while (!mode_req_ready && w < 50) begin
            w++;
            tick();
        end
        if (w >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_ready_wait: ready still 0 after %0d cycles, expected 1", w);
        end
        sof = sof_with;
        tick();
        mode_req_valid = 1'b0;
        sof            = 1'b0;
        $display("req  sel=%0d accepted", s);
    endtask

    // Monitor: every mode_done pulse must match the oldest queued expectation.
    always @(negedge aclk) begin
        if (aresetn && mode_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_mode_done: got pulse with cur_mode=%0d, expected none", cur_mode);
            end else begin
                mon_e = sb_q.pop_front();
                chk_timing("done", mon_e);
                chk("done_init", 32'(init), 32'd0);
                chk("done_busy", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   k;
        aresetn        = 1'b0;
        mode_req_valid = 1'b0;
        mode_req_sel   = 2'd0;
        sof            = 1'b0;
        pix_tvalid     = 1'b0;
        pix_tready     = 1'b0;
        underflow_clr  = 1'b0;

        // 1: reset state and start-up init pulse
        repeat (3) tick();
        chk_reset("rst");
        aresetn = 1'b1;
        count_init("t1_init_len");
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_ready", 32'(mode_req_ready), 32'd1);
        chk_timing("t1", exp_for(2'd3));

        // 3: request the active mode
        sb_q.push_back(exp_for(2'd3));
        request(2'd3, 1'b0);
        chk("t3_done", 32'(mode_done), 32'd1);
        chk("t3_ready", 32'(mode_req_ready), 32'd1);
        seen = 1'b0;
        repeat (5) begin
            seen |= init;
            tick();
        end
        chk("t3_init_stays_low", 32'(seen), 32'd0);

        // 2: 3 -> 0, waits for sof
        sb_q.push_back(exp_for(2'd0));
        request(2'd0, 1'b0);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_ready", 32'(mode_req_ready), 32'd0);
        seen = 1'b0;
        repeat (10) begin
            seen |= init;
            tick();
        end
        chk("t2_no_init_before_sof", 32'(seen), 32'd0);
        chk("t2_h_res_held", 32'(h_res), 32'd8);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        chk("t2_init_rise", 32'(init), 32'd1);
        chk_timing("t2_on_init", exp_for(2'd0));
        count_init("t2_init_len");
        chk("t2_done", 32'(mode_done), 32'd1);
        chk("t2_ready_back", 32'(mode_req_ready), 32'd1);

        // 4: 0 -> 1 with sof only on the accepting cycle, so the timeout forces the switch
        sb_q.push_back(exp_for(2'd1));
        request(2'd1, 1'b1);
        k = 0;
        while (!init && k < 300) begin
            tick();
            k++;
        end
        chk("t4_timeout_cycles", 32'(k), 32'd100);
        chk_timing("t4_on_init", exp_for(2'd1));
        count_init("t4_init_len");

        // 5: reset while waiting for sof drops the request
        request(2'd2, 1'b0);
        repeat (5) tick();
        chk("t5_waiting", 32'(busy), 32'd1);
        aresetn = 1'b0;
        #2;
        chk_reset("t5_rst");
        tick();
        aresetn = 1'b1;
        count_init("t5_init_len");
        repeat (3) begin
            sof = 1'b1;
            tick();
            sof = 1'b0;
            repeat (4) tick();
        end
        chk("t5_busy", 32'(busy), 32'd0);
        chk_timing("t5_after", exp_for(2'd3));

        // 6: underflow counter
        pix_tready = 1'b1;
        repeat (5) tick();
        pix_tready = 1'b0;
`ifdef VGA_MODE_CTRL_UNDERFLOW_EN
        chk("t6_uf_5", 32'(underflow_cnt), 32'd5);
        pix_tvalid = 1'b1;
        pix_tready = 1'b1;
        repeat (3) tick();
        pix_tvalid = 1'b0;
        pix_tready = 1'b0;
        chk("t6_uf_no_starve", 32'(underflow_cnt), 32'd5);
        underflow_clr = 1'b1;
        pix_tready    = 1'b1;
        tick();
        underflow_clr = 1'b0;
        pix_tready    = 1'b0;
        chk("t6_uf_clr_wins", 32'(underflow_cnt), 32'd0);
        pix_tready = 1'b1;
        repeat (65540) tick();
        pix_tready = 1'b0;
        chk("t6_uf_saturate", 32'(underflow_cnt), 32'hFFFF);
        sb_q.push_back(exp_for(2'd2));
        request(2'd2, 1'b0);
        chk("t6_uf_hold_wait", 32'(underflow_cnt), 32'hFFFF);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        chk("t6_uf_init_clear", 32'(underflow_cnt), 32'd0);
        count_init("t6_init_len");
`else
        chk("t6_uf_disabled", 32'(underflow_cnt), 32'd0);
`endif

        repeat (5) tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
